// File: rtl/pa_clint_busif.sv
// pa_clint_busif: bus-side access controller for the CLINT register file.
// Accepts one 32-bit request at a time, decodes it, drives register selects
// and the write strobe for one EXEC cycle, then returns a registered response.
// An mtime_lo read snapshots mtime_hi so a following mtime_hi read is coherent.
module pa_clint_busif #(
    parameter int ADDR_WIDTH    = 16,
    parameter bit MTIME_SNAP_EN = 1'b1
) (
    input  logic                  clint_clk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_mode,
    output logic                  resp_vld,
    input  logic                  resp_rdy,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busif_regs_msip_sel,
    output logic                  busif_regs_mtimecmp_lo_sel,
    output logic                  busif_regs_mtimecmp_hi_sel,
    output logic [31:0]           busif_regs_wdata,
    output logic                  busif_regs_write_vld,
    input  logic [31:0]           msip_value,
    input  logic [31:0]           mtimecmp_lo_value,
    input  logic [31:0]           mtimecmp_hi_value,
    input  logic [31:0]           mtime_lo_value,
    input  logic [31:0]           mtime_hi_value
);

    localparam logic [ADDR_WIDTH-1:0] OFF_MSIP     = ADDR_WIDTH'(32'h0000);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTCMP_LO = ADDR_WIDTH'(32'h4000);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTCMP_HI = ADDR_WIDTH'(32'h4004);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_LO = ADDR_WIDTH'(32'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_HI = ADDR_WIDTH'(32'hBFFC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  write_q;
    logic [1:0]            mode_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  snap_vld_q, snap_vld_d;
    logic [31:0]           snap_hi_q, snap_hi_d;

    logic accept;
    logic hit_msip, hit_mtcmp_lo, hit_mtcmp_hi, hit_mtime_lo, hit_mtime_hi;
    logic acc_err;
    logic mtime_lo_rd_ok;

    assign accept = (state_q == IDLE) && req_vld;

    // Latch the request on handshake; it is held for the whole access.
    always_ff @(posedge clint_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            mode_q  <= 2'b00;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            mode_q  <= req_mode;
        end
    end

    // Address decode and access legality of the latched request.
    always_comb begin
        hit_msip     = (addr_q == OFF_MSIP);
        hit_mtcmp_lo = (addr_q == OFF_MTCMP_LO);
        hit_mtcmp_hi = (addr_q == OFF_MTCMP_HI);
        hit_mtime_lo = (addr_q == OFF_MTIME_LO);
        hit_mtime_hi = (addr_q == OFF_MTIME_HI);
        acc_err = (addr_q[1:0] != 2'b00)
                | !(hit_msip | hit_mtcmp_lo | hit_mtcmp_hi | hit_mtime_lo | hit_mtime_hi)
                | (write_q & (hit_mtime_lo | hit_mtime_hi))
                | (write_q & (mode_q != 2'b11));
        mtime_lo_rd_ok = !acc_err && !write_q && hit_mtime_lo;
    end

    // Read data mux; errors and writes return zero.
    always_comb begin
        rdata_d = 32'h0;
        err_d   = acc_err;
        if (!acc_err && !write_q) begin
            if (hit_msip)     rdata_d = msip_value;
            if (hit_mtcmp_lo) rdata_d = mtimecmp_lo_value;
            if (hit_mtcmp_hi) rdata_d = mtimecmp_hi_value;
            if (hit_mtime_lo) rdata_d = mtime_lo_value;
            if (hit_mtime_hi) rdata_d = snap_vld_q ? snap_hi_q : mtime_hi_value;
        end
    end

    // Snapshot update: armed by an mtime_lo read, cleared by any other access.
    always_comb begin
        snap_vld_d = snap_vld_q;
        snap_hi_d  = snap_hi_q;
        if (state_q == EXEC) begin
            snap_vld_d = MTIME_SNAP_EN && mtime_lo_rd_ok;
            if (MTIME_SNAP_EN && mtime_lo_rd_ok) snap_hi_d = mtime_hi_value;
        end
    end

    // Response and snapshot registers, loaded at the end of EXEC.
    always_ff @(posedge clint_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            snap_vld_q <= 1'b0;
            snap_hi_q  <= 32'h0;
        end else begin
            if (state_q == EXEC) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            snap_vld_q <= snap_vld_d;
            snap_hi_q  <= snap_hi_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clint_clk or negedge cpurst_b) begin
        if (!cpurst_b) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next state: one access in flight, EXEC lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_vld) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes from state, selects/strobe only in EXEC.
    always_comb begin
        req_rdy                    = (state_q == IDLE);
        resp_vld                   = (state_q == RESP);
        busif_regs_msip_sel        = (state_q == EXEC) && !acc_err && hit_msip;
        busif_regs_mtimecmp_lo_sel = (state_q == EXEC) && !acc_err && hit_mtcmp_lo;
        busif_regs_mtimecmp_hi_sel = (state_q == EXEC) && !acc_err && hit_mtcmp_hi;
        busif_regs_write_vld       = (state_q == EXEC) && write_q && !acc_err;
        busif_regs_wdata           = wdata_q;
        resp_rdata                 = rdata_q;
        resp_err                   = err_q;
    end

endmodule
